// File: rtl/hpbar_pkg.sv
// ---------------------------------------------------------------------------
// hpbar_pkg
// Shared types and width helpers for the animated HP bar.
//   state_t    : control FSM states (IDLE -> DIV -> APPLY -> IDLE)
//   clog2      : bits needed to hold the values 0..n-1
//   quot_bits  : width of a fill value in 0..f_width
//   div_cycles : numerator width of the scaled division, which is also the
//                number of cycles the 1-bit-per-cycle divider needs
// ---------------------------------------------------------------------------
package hpbar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        APPLY
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int quot_bits(input int f_width);
        return clog2(f_width + 1);
    endfunction

    function automatic int div_cycles(input int w, input int f_width);
        return w + quot_bits(f_width);
    endfunction

endpackage

// File: rtl/hpbar_anim_divider.sv
// ---------------------------------------------------------------------------
// hp_seq_divider
// Restoring unsigned divider, one numerator bit per clock.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load numerator/denominator and (re)start; aborts any
//                    division already in flight
//   i_numer [NW]   : dividend
//   i_denom [DW]   : divisor (caller guarantees non-zero)
//   o_done         : one-cycle pulse, the cycle after the last bit resolves
//   o_quot  [QW]   : low QW bits of the quotient, valid from o_done until
//                    the next i_start
// A division takes NW cycles after the start edge.
// ---------------------------------------------------------------------------
module hp_seq_divider
    import hpbar_pkg::*;
#(
    parameter int NW = 25,
    parameter int DW = 16,
    parameter int QW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [NW-1:0] i_numer,
    input  logic [DW-1:0] i_denom,
    output logic          o_done,
    output logic [QW-1:0] o_quot
);

    localparam int CW = clog2(NW + 1);

    // quot_q starts as the numerator and is shifted left each step; the
    // freed LSB collects the quotient bit, so after NW steps it holds
    // the full quotient.
    logic [NW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] den_q, den_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [DW:0]   r_shift;
    logic [DW:0]   r_diff;

    always_comb begin
        quot_d  = quot_q;
        rem_d   = rem_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        r_shift = '0;
        r_diff  = '0;

        if (i_start) begin
            quot_d = i_numer;
            rem_d  = '0;
            den_d  = i_denom;
            cnt_d  = CW'(NW);
        end else if (cnt_q != '0) begin
            // Partial remainder stays below the divisor, so the shifted
            // value fits in DW+1 bits and the difference back in DW bits.
            r_shift = {rem_q, quot_q[NW-1]};
            if (r_shift >= {1'b0, den_q}) begin
                r_diff = r_shift - {1'b0, den_q};
                rem_d  = r_diff[DW-1:0];
                quot_d = {quot_q[NW-2:0], 1'b1};
            end else begin
                rem_d  = r_shift[DW-1:0];
                quot_d = {quot_q[NW-2:0], 1'b0};
            end
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_done = done_q;
    assign o_quot = quot_q[QW-1:0];

endmodule

// File: rtl/hpbar_anim.sv
// ---------------------------------------------------------------------------
// hpbar_anim
// Animated HP bar geometry: scales remain/total HP to a fill width of
// F_WIDTH pixels with a sequential divider, then animates the fill and a
// trailing damage "ghost" on the frame tick.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_load                : strobe, sample i_total_hp / i_remain_hp
//   i_total_hp [W]        : maximum HP
//   i_remain_hp [W]       : current HP (clamped to total)
//   i_tick                : frame strobe driving the animation
//   o_busy                : division in progress
//   o_lt_x/o_lt_y [W]     : fill top-left corner (constant)
//   o_br_x/o_br_y [W]     : fill bottom-right corner
//   o_ghost_br_x [W]      : ghost right edge, never left of o_br_x
//   o_empty               : fill width is zero
// ---------------------------------------------------------------------------
module hpbar_anim
    import hpbar_pkg::*;
#(
    parameter int W          = 16,
    parameter int F_WIDTH    = 300,
    parameter int F_HEIGHT   = 16,
    parameter int FX         = 240,
    parameter int FY         = 400,
    parameter int STEP       = 2,
    parameter int GHOST_HOLD = 30
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_total_hp,
    input  logic [W-1:0] i_remain_hp,
    input  logic         i_tick,
    output logic         o_busy,
    output logic [W-1:0] o_lt_x,
    output logic [W-1:0] o_lt_y,
    output logic [W-1:0] o_br_x,
    output logic [W-1:0] o_br_y,
    output logic [W-1:0] o_ghost_br_x,
    output logic         o_empty
);

    localparam int QB     = quot_bits(F_WIDTH);
    localparam int QB1    = QB + 1;
    localparam int NW     = div_cycles(W, F_WIDTH);
    localparam int HB_RAW = clog2(GHOST_HOLD + 1);
    localparam int HB     = (HB_RAW > 0) ? HB_RAW : 1;

    localparam logic [NW-1:0]  F_WIDTH_N = NW'(F_WIDTH);
    localparam logic [QB-1:0]  FULL      = QB'(F_WIDTH);
    localparam logic [QB-1:0]  STEP_Q    = QB'(STEP);
    localparam logic [QB1-1:0] STEP_X    = QB1'(STEP);
    localparam logic [HB-1:0]  HOLD_LOAD = HB'(GHOST_HOLD);
    localparam logic [W-1:0]   FX_W      = W'(FX);
    localparam logic [W-1:0]   FY_W      = W'(FY);
    localparam logic [W-1:0]   FH_W      = W'(F_HEIGHT);

    state_t        state_q, state_d;
    logic [QB-1:0] quot_q, quot_d;
    logic [QB-1:0] target_q, target_d;
    logic [QB-1:0] disp_q, disp_d;
    logic [QB-1:0] ghost_q, ghost_d;
    logic [HB-1:0] hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          empty_q, empty_d;

    logic [W-1:0]   rem_clamp;
    logic [NW-1:0]  div_numer;
    logic           div_start;
    logic           div_done;
    logic [QB-1:0]  div_quot;
    logic           apply_now;
    logic [QB1-1:0] heal_sum;
    logic [QB1-1:0] drain_floor;

    // Clamping remain to total keeps the quotient within 0..F_WIDTH, so
    // only its low QB bits are ever needed.
    assign rem_clamp = (i_remain_hp > i_total_hp) ? i_total_hp : i_remain_hp;
    assign div_numer = F_WIDTH_N * NW'(rem_clamp);

    hp_seq_divider #(
        .NW (NW),
        .DW (W),
        .QW (QB)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (div_start),
        .i_numer (div_numer),
        .i_denom (i_total_hp),
        .o_done  (div_done),
        .o_quot  (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        quot_d      = quot_q;
        target_d    = target_q;
        disp_d      = disp_q;
        ghost_d     = ghost_q;
        hold_d      = hold_q;
        div_start   = 1'b0;
        apply_now   = 1'b0;
        heal_sum    = '0;
        drain_floor = '0;
        // Registered one cycle behind the DIV state, so the flag rises the
        // edge after the load and drops on the edge the new target lands.
        busy_d      = (state_q == DIV);

        // A load in any state restarts the computation so the latest
        // sample wins; a zero total has nothing to divide and goes
        // straight to APPLY with an empty bar.
        if (i_load) begin
            if (i_total_hp == '0) begin
                quot_d  = '0;
                state_d = APPLY;
            end else begin
                div_start = 1'b1;
                state_d   = DIV;
            end
        end else begin
            case (state_q)
                DIV: begin
                    if (div_done) begin
                        quot_d  = div_quot;
                        state_d = APPLY;
                    end
                end
                APPLY: begin
                    apply_now = 1'b1;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Damage snaps the fill down immediately and parks the ghost at
        // its old position; healing is left to the tick animation. A tick
        // landing on the apply cycle is dropped.
        if (apply_now) begin
            target_d = quot_q;
            if (quot_q < disp_q) begin
                disp_d = quot_q;
                hold_d = HOLD_LOAD;
            end
        end else if (i_tick) begin
            if (disp_q < target_q) begin
                heal_sum = {1'b0, disp_q} + STEP_X;
                disp_d   = (heal_sum > {1'b0, target_q}) ? target_q : heal_sum[QB-1:0];
            end
            // The ghost is never allowed to sit left of the fill: while
            // holding it is only pushed up by a healing fill, and while
            // draining it stops at the fill.
            drain_floor = {1'b0, disp_d} + STEP_X;
            if (hold_q != '0) begin
                hold_d = hold_q - HB'(1);
                if (ghost_q < disp_d) begin
                    ghost_d = disp_d;
                end
            end else if ({1'b0, ghost_q} >= drain_floor) begin
                ghost_d = ghost_q - STEP_Q;
            end else begin
                ghost_d = disp_d;
            end
        end

        empty_d = (disp_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            quot_q   <= '0;
            target_q <= FULL;
            disp_q   <= FULL;
            ghost_q  <= FULL;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            quot_q   <= quot_d;
            target_q <= target_d;
            disp_q   <= disp_d;
            ghost_q  <= ghost_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            empty_q  <= empty_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_empty      = empty_q;
    assign o_lt_x       = FX_W;
    assign o_lt_y       = FY_W;
    assign o_br_x       = FX_W + W'(disp_q);
    assign o_br_y       = FY_W + FH_W;
    assign o_ghost_br_x = FX_W + W'(ghost_q);

endmodule

// File: tb/tb_hpbar_anim.sv
// ---------------------------------------------------------------------------
// tb_hpbar_anim
// Directed bench for hpbar_anim with default parameters (W=16, F_WIDTH=300,
// FX=240, FY=400, F_HEIGHT=16, STEP=2, GHOST_HOLD=30). Expected pixel
// values are worked out by hand from the bar geometry.
// ---------------------------------------------------------------------------
module tb_hpbar_anim;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_load;
    logic [W-1:0] i_total_hp;
    logic [W-1:0] i_remain_hp;
    logic         i_tick;
    logic         o_busy;
    logic [W-1:0] o_lt_x;
    logic [W-1:0] o_lt_y;
    logic [W-1:0] o_br_x;
    logic [W-1:0] o_br_y;
    logic [W-1:0] o_ghost_br_x;
    logic         o_empty;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [W-1:0] total;
        logic [W-1:0] remain;
        int           nticks;
        logic [W-1:0] exp_br_x;
        logic [W-1:0] exp_ghost_x;
        logic         exp_empty;
    } vec_t;

    vec_t vecs [7];

    hpbar_anim dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (i_load),
        .i_total_hp   (i_total_hp),
        .i_remain_hp  (i_remain_hp),
        .i_tick       (i_tick),
        .o_busy       (o_busy),
        .o_lt_x       (o_lt_x),
        .o_lt_y       (o_lt_y),
        .o_br_x       (o_br_x),
        .o_br_y       (o_br_y),
        .o_ghost_br_x (o_ghost_br_x),
        .o_empty      (o_empty)
    );

    always #5 i_clk = ~i_clk;

    // Global watchdog so a broken design can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one active edge and settle just past it.
    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) begin
            i_tick = 1'b1;
            cycle();
            i_tick = 1'b0;
        end
    endtask

    // One load strobe, enough idle cycles for the longest division, then
    // the requested number of frame ticks.
    task automatic applyStimulus(input logic [W-1:0] total, input logic [W-1:0] remain,
                                 input int nticks);
        i_total_hp  = total;
        i_remain_hp = remain;
        i_load      = 1'b1;
        cycle();
        i_load = 1'b0;
        repeat (30) cycle();
        doTicks(nticks);
    endtask

    initial begin
        int busyCount;

        vecs[0] = '{total: 16'd100,   remain: 16'd100,   nticks: 0,   exp_br_x: 16'd540, exp_ghost_x: 16'd540, exp_empty: 1'b0};
        vecs[1] = '{total: 16'd0,     remain: 16'd7,     nticks: 0,   exp_br_x: 16'd240, exp_ghost_x: 16'd540, exp_empty: 1'b1};
        vecs[2] = '{total: 16'd100,   remain: 16'd150,   nticks: 150, exp_br_x: 16'd540, exp_ghost_x: 16'd540, exp_empty: 1'b0};
        vecs[3] = '{total: 16'd3,     remain: 16'd1,     nticks: 0,   exp_br_x: 16'd340, exp_ghost_x: 16'd540, exp_empty: 1'b0};
        vecs[4] = '{total: 16'd65535, remain: 16'd65535, nticks: 100, exp_br_x: 16'd540, exp_ghost_x: 16'd540, exp_empty: 1'b0};
        vecs[5] = '{total: 16'd65535, remain: 16'd1,     nticks: 0,   exp_br_x: 16'd240, exp_ghost_x: 16'd540, exp_empty: 1'b1};
        vecs[6] = '{total: 16'd3,     remain: 16'd0,     nticks: 200, exp_br_x: 16'd240, exp_ghost_x: 16'd240, exp_empty: 1'b1};

        i_rst_n     = 1'b0;
        i_load      = 1'b0;
        i_tick      = 1'b0;
        i_total_hp  = '0;
        i_remain_hp = '0;
        repeat (3) cycle();
        i_rst_n = 1'b1;
        cycle();

        $display("[TB] reset state");
        checkOutput("reset lt_x", int'(o_lt_x), 240);
        checkOutput("reset lt_y", int'(o_lt_y), 400);
        checkOutput("reset br_x", int'(o_br_x), 540);
        checkOutput("reset br_y", int'(o_br_y), 416);
        checkOutput("reset ghost", int'(o_ghost_br_x), 540);
        checkOutput("reset busy", int'(o_busy), 0);
        checkOutput("reset empty", int'(o_empty), 0);

        $display("[TB] damage 50/100 with exact latency and ghost drain");
        i_total_hp  = 16'd100;
        i_remain_hp = 16'd50;
        i_load      = 1'b1;
        cycle();
        i_load = 1'b0;
        checkOutput("busy at load edge", int'(o_busy), 0);
        busyCount = 0;
        for (int n = 1; n <= 27; n++) begin
            cycle();
            if (o_busy) busyCount++;
            if (n == 26) checkOutput("br_x before apply", int'(o_br_x), 540);
        end
        checkOutput("busy cycle count", busyCount, 26);
        checkOutput("br_x at apply", int'(o_br_x), 390);
        checkOutput("busy after apply", int'(o_busy), 0);
        checkOutput("ghost after damage", int'(o_ghost_br_x), 540);
        doTicks(30);
        checkOutput("ghost held 30 ticks", int'(o_ghost_br_x), 540);
        doTicks(1);
        checkOutput("ghost first drain", int'(o_ghost_br_x), 538);
        doTicks(74);
        checkOutput("ghost drained", int'(o_ghost_br_x), 390);
        doTicks(1);
        checkOutput("ghost saturates", int'(o_ghost_br_x), 390);
        checkOutput("br_x steady", int'(o_br_x), 390);

        $display("[TB] heal 150 -> 300");
        applyStimulus(16'd100, 16'd100, 0);
        checkOutput("heal not instant", int'(o_br_x), 390);
        doTicks(1);
        checkOutput("heal first step", int'(o_br_x), 392);
        checkOutput("heal ghost follows", int'(o_ghost_br_x), 392);
        doTicks(74);
        checkOutput("heal full", int'(o_br_x), 540);
        checkOutput("heal ghost full", int'(o_ghost_br_x), 540);
        doTicks(1);
        checkOutput("heal saturates", int'(o_br_x), 540);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].total, vecs[i].remain, vecs[i].nticks);
            checkOutput($sformatf("vec%0d br_x", i), int'(o_br_x), int'(vecs[i].exp_br_x));
            checkOutput($sformatf("vec%0d ghost", i), int'(o_ghost_br_x), int'(vecs[i].exp_ghost_x));
            checkOutput($sformatf("vec%0d empty", i), int'(o_empty), int'(vecs[i].exp_empty));
        end

        $display("[TB] reload mid-division, latest wins");
        i_total_hp  = 16'd7;
        i_remain_hp = 16'd3;
        i_load      = 1'b1;
        cycle();
        i_load = 1'b0;
        repeat (4) cycle();
        i_remain_hp = 16'd6;
        i_load      = 1'b1;
        cycle();
        i_load = 1'b0;
        repeat (22) cycle();
        checkOutput("restart keeps busy", int'(o_busy), 1);
        repeat (10) cycle();
        checkOutput("restart done", int'(o_busy), 0);
        doTicks(140);
        checkOutput("floor(1800/7) fill", int'(o_br_x), 497);
        checkOutput("floor(1800/7) ghost", int'(o_ghost_br_x), 497);
        applyStimulus(16'd3, 16'd1, 0);
        checkOutput("1/3 truncation", int'(o_br_x), 340);
        checkOutput("1/3 ghost held", int'(o_ghost_br_x), 497);

        $display("[TB] reset mid-division");
        i_total_hp  = 16'd7;
        i_remain_hp = 16'd6;
        i_load      = 1'b1;
        cycle();
        i_load = 1'b0;
        repeat (10) cycle();
        checkOutput("busy before reset", int'(o_busy), 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("async reset br_x", int'(o_br_x), 540);
        checkOutput("async reset ghost", int'(o_ghost_br_x), 540);
        checkOutput("async reset busy", int'(o_busy), 0);
        checkOutput("async reset empty", int'(o_empty), 0);
        #2;
        i_rst_n = 1'b1;
        repeat (40) cycle();
        checkOutput("no stale apply br_x", int'(o_br_x), 540);
        checkOutput("no stale busy", int'(o_busy), 0);

        $display("[TB] reset mid ghost drain");
        applyStimulus(16'd100, 16'd50, 40);
        checkOutput("drain br_x", int'(o_br_x), 390);
        checkOutput("drain ghost", int'(o_ghost_br_x), 520);
        i_rst_n = 1'b0;
        #1;
        checkOutput("drain reset br_x", int'(o_br_x), 540);
        checkOutput("drain reset ghost", int'(o_ghost_br_x), 540);
        #2;
        i_rst_n = 1'b1;
        repeat (5) cycle();
        doTicks(5);
        checkOutput("post reset br_x", int'(o_br_x), 540);
        checkOutput("post reset ghost", int'(o_ghost_br_x), 540);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
